roll_sequencer: RTL and testbench

Controller that sequences one die roll end to end. It latches the die type and collects random bits from the entropy source one at a time. It maps those bits to a face value 1..N by rejection sampling, presents the result, and serialises it to the UART transmitter as ASCII digits. It sits between the debounced/encoded button inputs, the random-bit source and the uart block, and replaces ad-hoc glue in top.

---
 rtl/roll_sequencer.sv | 177 +++++++++++++++++
 tb/tb_roll_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roll_sequencer.sv
// rtl/roll_sequencer.sv - die roll sequencer: entropy gather, rejection sampling, ASCII UART output
module roll_sequencer #(
  parameter int RAND_WIDTH = 8,
  parameter int MAX_RETRY  = 15,
  parameter bit SEND_UART  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       roll_req,
  input  logic [2:0] die_sel,
  input  logic       rand_bit,
  input  logic       rand_valid,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [6:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(RAND_WIDTH + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_GATHER, S_CHECK, S_REDUCE, S_DIGIT, S_TX_H, S_TX_T, S_TX_O, S_TX_LF
  } state_t;

  state_t                state, state_nxt;
  logic [6:0]            sides;
  logic [8:0]            limit;
  logic [RAND_WIDTH-1:0] sample;
  logic [CW-1:0]         bit_cnt;
  logic [RW-1:0]         retry;
  logic [6:0]            work;
  logic [3:0]            dig_h, dig_t;
  logic                  sample_ok, sample_ge_n, retry_done, last_bit;

  function automatic logic [6:0] die_sides(input logic [2:0] code);
    case (code)
      3'd0:    die_sides = 7'd4;
      3'd1:    die_sides = 7'd6;
      3'd2:    die_sides = 7'd8;
      3'd3:    die_sides = 7'd10;
      3'd4:    die_sides = 7'd12;
      3'd5:    die_sides = 7'd20;
      3'd6:    die_sides = 7'd100;
      default: die_sides = 7'd2;
    endcase
  endfunction

  // Largest multiple of N that fits in 256, so every face is equally likely.
  function automatic logic [8:0] die_limit(input logic [2:0] code);
    case (code)
      3'd1, 3'd4: die_limit = 9'd252;
      3'd3:       die_limit = 9'd250;
      3'd5:       die_limit = 9'd240;
      3'd6:       die_limit = 9'd200;
      default:    die_limit = 9'd256;
    endcase
  endfunction

  assign sample_ok   = 9'(sample) < limit;
  assign sample_ge_n = sample >= RAND_WIDTH'(sides);
  assign retry_done  = retry == RW'(MAX_RETRY - 1);
  assign last_bit    = bit_cnt == CW'(RAND_WIDTH - 1);
  assign busy        = state != S_IDLE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      S_IDLE:   if (roll_req) state_nxt = S_GATHER;
      S_GATHER: if (rand_valid && last_bit) state_nxt = S_CHECK;
      S_CHECK: begin
        if (sample_ok)       state_nxt = S_REDUCE;
        else if (retry_done) state_nxt = S_IDLE;
        else                 state_nxt = S_GATHER;
      end
      S_REDUCE: if (!sample_ge_n) state_nxt = S_DIGIT;
      S_DIGIT: begin
        if (!SEND_UART)          state_nxt = S_IDLE;
        else if (work < 7'd10)   state_nxt = S_TX_H;
      end
      S_TX_H: begin
        tx_valid = 1'b1;
        tx_data  = 8'h30 + {4'h0, dig_h};
        if (tx_ready) state_nxt = S_TX_T;
      end
      S_TX_T: begin
        tx_valid = 1'b1;
        tx_data  = 8'h30 + {4'h0, dig_t};
        if (tx_ready) state_nxt = S_TX_O;
      end
      S_TX_O: begin
        tx_valid = 1'b1;
        tx_data  = 8'h30 + {4'h0, work[3:0]};
        if (tx_ready) state_nxt = S_TX_LF;
      end
      S_TX_LF: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
        if (tx_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sides        <= '0;
      limit        <= '0;
      sample       <= '0;
      bit_cnt      <= '0;
      retry        <= '0;
      work         <= '0;
      dig_h        <= '0;
      dig_t        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      err          <= 1'b0;
      case (state)
        S_IDLE: if (roll_req) begin
          sides   <= die_sides(die_sel);
          limit   <= die_limit(die_sel);
          sample  <= '0;
          bit_cnt <= '0;
          retry   <= '0;
        end
        S_GATHER: if (rand_valid) begin
          sample  <= {sample[RAND_WIDTH-2:0], rand_bit};
          bit_cnt <= bit_cnt + CW'(1);
        end
        S_CHECK: if (!sample_ok) begin
          retry   <= retry + RW'(1);
          bit_cnt <= '0;
          if (retry_done) begin
            err    <= 1'b1;
            result <= '0;
          end
        end
        S_REDUCE: begin
          if (sample_ge_n) begin
            sample <= sample - RAND_WIDTH'(sides);
          end else begin
            result       <= sample[6:0] + 7'd1;
            result_valid <= 1'b1;
            work         <= sample[6:0] + 7'd1;
            dig_h        <= '0;
            dig_t        <= '0;
          end
        end
        // Remainder left in work after the tens pass is the ones digit.
        S_DIGIT: begin
          if (work >= 7'd100) begin
            work  <= work - 7'd100;
            dig_h <= dig_h + 4'd1;
          end else if (work >= 7'd10) begin
            work  <= work - 7'd10;
            dig_t <= dig_t + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_roll_sequencer.sv
// tb/tb_roll_sequencer.sv - self-checking bench for roll_sequencer against a rejection-sampling model
module tb_roll_sequencer;

  logic       clk, reset_n, roll_req, rand_bit, rand_valid, tx_ready;
  logic [2:0] die_sel;
  logic       tx_valid, result_valid, busy, err;
  logic [7:0] tx_data;
  logic [6:0] result;

  roll_sequencer dut (
    .clk(clk), .reset_n(reset_n), .roll_req(roll_req), .die_sel(die_sel),
    .rand_bit(rand_bit), .rand_valid(rand_valid), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .result(result),
    .result_valid(result_valid), .busy(busy), .err(err)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int sides_tab[8] = '{4, 6, 8, 10, 12, 20, 100, 2};

  logic [6:0] rv_q[$];
  logic [7:0] tx_q[$];
  int err_cnt = 0, both_cnt = 0, viol_cnt = 0, stall_cnt = 0, seen_cnt = 0;
  int rv_b, tx_b, err_b, both_b, viol_b, stall_b, seen_b;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] smp_q[$];
  logic [7:0] exp_tx[$];
  bit stall_on = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (result_valid) rv_q.push_back(result);
      if (err) err_cnt++;
      if (result_valid && err) both_cnt++;
      if (tx_valid) seen_cnt++;
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (tx_valid && !tx_ready && (tx_q.size() - tx_b) == 1) stall_cnt++;
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) viol_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Stalls the tens byte for 20 cycles when requested, otherwise random backpressure.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_on && tx_valid && (tx_q.size() - tx_b) == 1 && (stall_cnt - stall_b) < 20)
        tx_ready = 1'b0;
      else
        tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic mark();
    rv_b = rv_q.size(); tx_b = tx_q.size(); err_b = err_cnt; both_b = both_cnt;
    viol_b = viol_cnt; stall_b = stall_cnt; seen_b = seen_cnt;
  endtask

  task automatic model_roll(input int die, output int exp_res, output bit exp_err);
    int n, l, rej;
    n = sides_tab[die];
    l = 256 - (256 % n);
    rej = 0; exp_res = 0; exp_err = 1'b0;
    exp_tx.delete();
    foreach (smp_q[i]) begin
      if (int'(smp_q[i]) < l) begin exp_res = int'(smp_q[i]) % n + 1; break; end
      rej++;
      if (rej == 15) begin exp_err = 1'b1; break; end
    end
    if (!exp_err) begin
      exp_tx.push_back(8'(8'h30 + exp_res / 100));
      exp_tx.push_back(8'(8'h30 + (exp_res / 10) % 10));
      exp_tx.push_back(8'(8'h30 + exp_res % 10));
      exp_tx.push_back(8'h0A);
    end
  endtask

  task automatic start_roll(input int die);
    @(posedge clk); #1;
    roll_req = 1'b1; die_sel = 3'(die);
    @(posedge clk); #1;
    roll_req = 1'b0; die_sel = 3'($urandom_range(0, 7));
  endtask

  task automatic feed_byte(input logic [7:0] b, input int gap);
    for (int i = 7; i >= 0; i--) begin
      rand_valid = 1'b1; rand_bit = b[i];
      @(posedge clk); #1;
      for (int g = 0; g < gap; g++) begin
        rand_valid = 1'b0; rand_bit = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    rand_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (!busy) begin ok = 1'b1; rand_valid = 1'b0; return; end
      rand_valid = 1'($urandom_range(0, 1));
      rand_bit   = 1'($urandom_range(0, 1));
    end
    rand_valid = 1'b0;
  endtask

  task automatic run_roll(input int die, input int gap, output bit ok);
    start_roll(die);
    foreach (smp_q[i]) feed_byte(smp_q[i], gap);
    wait_idle(ok);
  endtask

  function automatic bit tx_match();
    if ((tx_q.size() - tx_b) != exp_tx.size()) return 1'b0;
    foreach (exp_tx[i]) if (tx_q[tx_b + i] !== exp_tx[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; roll_req = 1'b0; die_sel = 3'd0; rand_bit = 1'b0; rand_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %0b exp 0", tx_valid); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %02h exp 00", tx_data); else pass_cnt++;
    total_cnt++; if (result !== 7'd0) $display("FAIL reset_result got %0d exp 0", result); else pass_cnt++;
    total_cnt++; if (result_valid !== 1'b0) $display("FAIL reset_result_valid got %0b exp 0", result_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %0b exp 0", err); else pass_cnt++;
    reset_n = 1'b1;
  endtask

  task automatic test_d6();
    int er; bit ee, ok;
    mark();
    smp_q = '{8'h2B};
    model_roll(1, er, ee);
    start_roll(1);
    total_cnt++; if (busy !== 1'b1) $display("FAIL d6_busy_rise got %0b exp 1", busy); else pass_cnt++;
    feed_byte(8'h2B, 0);
    wait_idle(ok);
    total_cnt++; if (!ok) $display("FAIL d6_timeout busy stuck got 1 exp 0"); else pass_cnt++;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL d6_tx_valid_idle got %0b exp 0", tx_valid); else pass_cnt++;
    total_cnt++;
    if ((rv_q.size() - rv_b) != 1 || rv_q[rv_b] !== 7'(er))
      $display("FAIL d6_result got n=%0d v=%0d exp n=1 v=%0d", rv_q.size() - rv_b, result, er);
    else pass_cnt++;
    total_cnt++; if (!tx_match()) $display("FAIL d6_tx_bytes got n=%0d exp n=%0d (30 30 32 0A)", tx_q.size() - tx_b, exp_tx.size()); else pass_cnt++;
    total_cnt++; if (err_cnt != err_b) $display("FAIL d6_err got %0d exp 0", err_cnt - err_b); else pass_cnt++;
  endtask

  task automatic test_d100_reject();
    int er; bit ee, ok;
    mark();
    smp_q = '{8'hC8, 8'h63};
    model_roll(6, er, ee);
    run_roll(6, 0, ok);
    total_cnt++; if (!ok) $display("FAIL d100_timeout busy stuck got 1 exp 0"); else pass_cnt++;
    total_cnt++;
    if ((rv_q.size() - rv_b) != 1 || result !== 7'(er))
      $display("FAIL d100_result got n=%0d v=%0d exp n=1 v=%0d", rv_q.size() - rv_b, result, er);
    else pass_cnt++;
    total_cnt++; if (!tx_match()) $display("FAIL d100_tx_bytes got n=%0d exp n=%0d (31 30 30 0A)", tx_q.size() - tx_b, exp_tx.size()); else pass_cnt++;
  endtask

  task automatic test_abort();
    int er; bit ee, ok;
    mark();
    smp_q.delete();
    for (int i = 0; i < 15; i++) smp_q.push_back(8'hFF);
    model_roll(5, er, ee);
    run_roll(5, 0, ok);
    total_cnt++; if (!ok) $display("FAIL abort_timeout busy stuck got 1 exp 0"); else pass_cnt++;
    total_cnt++; if ((err_cnt - err_b) != int'(ee)) $display("FAIL abort_err_pulses got %0d exp %0d", err_cnt - err_b, ee); else pass_cnt++;
    total_cnt++; if (result !== 7'(er)) $display("FAIL abort_result got %0d exp %0d", result, er); else pass_cnt++;
    total_cnt++; if (rv_q.size() != rv_b) $display("FAIL abort_result_valid got %0d exp 0", rv_q.size() - rv_b); else pass_cnt++;
    total_cnt++; if (seen_cnt != seen_b) $display("FAIL abort_tx_valid got %0d cycles exp 0", seen_cnt - seen_b); else pass_cnt++;
    mark();
    smp_q = '{8'($urandom_range(0, 255))};
    model_roll(0, er, ee);
    run_roll(0, 1, ok);
    total_cnt++;
    if (!ok || (rv_q.size() - rv_b) != 1 || result !== 7'(er))
      $display("FAIL abort_next_roll got ok=%0b n=%0d v=%0d exp ok=1 n=1 v=%0d", ok, rv_q.size() - rv_b, result, er);
    else pass_cnt++;
  endtask

  task automatic test_tx_stall();
    int er; bit ee, ok, hit;
    mark();
    smp_q = '{8'($urandom_range(0, 249))};
    model_roll(3, er, ee);
    stall_on = 1'b1;
    start_roll(3);
    feed_byte(smp_q[0], 0);
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk); #1;
      if ((stall_cnt - stall_b) >= 5) hit = 1'b1;
    end
    total_cnt++; if (!hit) $display("FAIL stall_reach_tens got 0 exp 1"); else pass_cnt++;
    total_cnt++;
    if (tx_valid !== 1'b1 || tx_data !== exp_tx[1])
      $display("FAIL stall_tens_hold got v=%0b d=%02h exp v=1 d=%02h", tx_valid, tx_data, exp_tx[1]);
    else pass_cnt++;
    start_roll(6);
    wait_idle(ok);
    stall_on = 1'b0;
    total_cnt++; if (!ok) $display("FAIL stall_timeout busy stuck got 1 exp 0"); else pass_cnt++;
    total_cnt++; if ((stall_cnt - stall_b) < 20) $display("FAIL stall_cycles got %0d exp >=20", stall_cnt - stall_b); else pass_cnt++;
    total_cnt++; if (viol_cnt != viol_b) $display("FAIL stall_data_stable got %0d violations exp 0", viol_cnt - viol_b); else pass_cnt++;
    total_cnt++; if (!tx_match()) $display("FAIL stall_tx_bytes got n=%0d exp n=%0d", tx_q.size() - tx_b, exp_tx.size()); else pass_cnt++;
    repeat (20) @(negedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || (rv_q.size() - rv_b) != 1 || result !== 7'(er))
      $display("FAIL stall_req_ignored got busy=%0b n=%0d v=%0d exp busy=0 n=1 v=%0d", busy, rv_q.size() - rv_b, result, er);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_tx();
    int er; bit ee, ok, hit;
    mark();
    smp_q = '{8'($urandom_range(0, 255))};
    start_roll(0);
    feed_byte(smp_q[0], 0);
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk); #1;
      if ((tx_q.size() - tx_b) == 2) hit = 1'b1;
    end
    total_cnt++; if (!hit || tx_valid !== 1'b1) $display("FAIL rst_reach_ones got hit=%0b v=%0b exp 1 1", hit, tx_valid); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00)
      $display("FAIL rst_mid_tx got v=%0b busy=%0b d=%02h exp 0 0 00", tx_valid, busy, tx_data);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    mark();
    smp_q = '{8'h03};
    model_roll(0, er, ee);
    run_roll(0, 0, ok);
    total_cnt++;
    if (!ok || (rv_q.size() - rv_b) != 1 || result !== 7'(er))
      $display("FAIL rst_d4_result got ok=%0b n=%0d v=%0d exp ok=1 n=1 v=%0d", ok, rv_q.size() - rv_b, result, er);
    else pass_cnt++;
    total_cnt++; if (!tx_match()) $display("FAIL rst_d4_tx_bytes got n=%0d exp n=%0d (30 30 34 0A)", tx_q.size() - tx_b, exp_tx.size()); else pass_cnt++;
  endtask

  task automatic test_rand_gaps();
    int er; bit ee, ok;
    mark();
    smp_q = '{8'hFF};
    model_roll(2, er, ee);
    run_roll(2, 2, ok);
    total_cnt++;
    if (!ok || (rv_q.size() - rv_b) != 1 || result !== 7'(er))
      $display("FAIL gaps_result got ok=%0b n=%0d v=%0d exp ok=1 n=1 v=%0d", ok, rv_q.size() - rv_b, result, er);
    else pass_cnt++;
    total_cnt++; if (!tx_match()) $display("FAIL gaps_tx_bytes got n=%0d exp n=%0d", tx_q.size() - tx_b, exp_tx.size()); else pass_cnt++;
  endtask

  task automatic test_random();
    int er, die, n, l, s; bit ee, ok, good;
    for (int it = 0; it < 25; it++) begin
      mark();
      die = $urandom_range(0, 7);
      n = sides_tab[die];
      l = 256 - (256 % n);
      smp_q.delete();
      for (int k = 0; k < 15; k++) begin
        s = $urandom_range(0, 255);
        if (l < 256 && $urandom_range(0, 2) == 0) s = $urandom_range(l, 255);
        smp_q.push_back(8'(s));
        if (s < l) break;
      end
      model_roll(die, er, ee);
      run_roll(die, $urandom_range(0, 2), ok);
      good = ok && result === 7'(er) && (err_cnt - err_b) == int'(ee) &&
             (rv_q.size() - rv_b) == (ee ? 0 : 1) && tx_match() && both_cnt == both_b;
      total_cnt++;
      if (!good)
        $display("FAIL random_roll it=%0d die=%0d got ok=%0b v=%0d err=%0d n=%0d tx=%0d exp v=%0d err=%0d tx=%0d",
                 it, die, ok, result, err_cnt - err_b, rv_q.size() - rv_b, tx_q.size() - tx_b, er, ee, exp_tx.size());
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_d6();
    test_d100_reject();
    test_abort();
    test_tx_stall();
    test_reset_mid_tx();
    test_rand_gaps();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
